// File: rtl/event_encoder_if.sv
// Output handshake between the event encoder and the readout controller.
// The encoder drives index + valid; the consumer drives ready.
interface event_encoder_if #(
    parameter int width = 8
) ();
    localparam int AW = $clog2(width);

    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;

    modport master (output out_valid, output out_addr, input out_ready);
    modport slave  (input out_valid, input out_addr, output out_ready);
endinterface

// File: rtl/event_encoder.sv
// Snapshot multi-hot request lines, then stream the index of each set bit in
// ascending order over a valid/ready handshake; done pulses after the last one.
module event_encoder #(
    parameter int width = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [width-1:0]     req,
    event_encoder_if.master      out,
    output logic                 busy,
    output logic                 done
);
    localparam int AW = $clog2(width);

    typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t           state_q;
    logic [width-1:0] pending_q;
    logic             done_q;

    logic             emit;
    logic [AW-1:0]    addr;
    logic [width-1:0] pending_d;

    function automatic logic [AW-1:0] lowest_idx(input logic [width-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (v[i]) idx = AW'(i);
        end
        return idx;
    endfunction

    // Outputs depend only on registered state; out_ready only feeds next-state.
    always_comb begin
        emit      = (state_q == EMIT);
        addr      = emit ? lowest_idx(pending_q) : '0;
        pending_d = pending_q;
        if (emit && out.out_ready) pending_d[addr] = 1'b0;
    end

    assign out.out_valid = emit;
    assign out.out_addr  = addr;
    assign busy          = emit;
    assign done          = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && (req != '0)) begin
                        pending_q <= req;
                        state_q   <= EMIT;
                    end
                end
                EMIT: begin
                    // Abort wins over completion: no done even if the last bit went out.
                    if (!enable) begin
                        pending_q <= '0;
                        state_q   <= IDLE;
                    end else if (pending_d == '0) begin
                        pending_q <= '0;
                        state_q   <= IDLE;
                        done_q    <= 1'b1;
                    end else begin
                        pending_q <= pending_d;
                    end
                end
                default: begin
                    pending_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_event_encoder.sv
// Directed bench for event_encoder: scan order, backpressure, snapshot
// isolation, abort, asynchronous reset and edge request patterns.
module tb_event_encoder;
    localparam int W  = 8;
    localparam int AW = $clog2(W);

    logic         clk;
    logic         reset;
    logic         enable;
    logic [W-1:0] req;
    logic         busy;
    logic         done;

    int tests;
    int fails;

    event_encoder_if #(.width(W)) bus ();

    event_encoder #(.width(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .req    (req),
        .out    (bus.master),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset         = 1'b0;
        enable        = 1'b0;
        req           = '0;
        bus.out_ready = 1'b0;
        #12;
        tests++;
        if ({bus.out_valid, bus.out_addr, busy, done} !== {1'b0, {AW{1'b0}}, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b a=%0d b=%b d=%b, want all 0",
                     bus.out_valid, bus.out_addr, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.out_valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_release_idle: got v=%b b=%b d=%b, want 000",
                     bus.out_valid, busy, done);
        end
    endtask

    task automatic test_basic_scan();
        logic [AW-1:0] exp_addr [3];
        exp_addr[0] = 3'd2; exp_addr[1] = 3'd5; exp_addr[2] = 3'd7;
        enable = 1'b1; bus.out_ready = 1'b1; req = 8'b1010_0100;
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || busy !== 1'b1 || bus.out_addr !== exp_addr[i] || done !== 1'b0) begin
                fails++;
                $display("FAIL basic_idx%0d: got v=%b b=%b a=%0d d=%b, want v=1 b=1 a=%0d d=0",
                         i, bus.out_valid, busy, bus.out_addr, done, exp_addr[i]);
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_addr !== 3'd0) begin
            fails++;
            $display("FAIL basic_done: got d=%b b=%b v=%b a=%0d, want d=1 b=0 v=0 a=0",
                     done, busy, bus.out_valid, bus.out_addr);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse: got d=%b, want 0", done);
        end
    endtask

    task automatic test_backpressure();
        enable = 1'b1; bus.out_ready = 1'b0; req = 8'b0000_0011;
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_addr !== 3'd0) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b a=%0d, want v=1 a=0", i, bus.out_valid, bus.out_addr);
            end
            if (i == 2) bus.out_ready = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 3'd1 || done !== 1'b0) begin
            fails++;
            $display("FAIL bp_second: got v=%b a=%0d d=%b, want v=1 a=1 d=0", bus.out_valid, bus.out_addr, done);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_done: got d=%b v=%b, want d=1 v=0", done, bus.out_valid);
        end
    endtask

    task automatic test_snapshot_isolation();
        @(negedge clk);
        enable = 1'b1; bus.out_ready = 1'b1; req = 8'b0001_0000;
        @(negedge clk);
        req = 8'hFF;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 3'd4) begin
            fails++;
            $display("FAIL iso_first: got v=%b a=%0d, want v=1 a=4", bus.out_valid, bus.out_addr);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL iso_done: got d=%b v=%b b=%b, want d=1 v=0 b=0", done, bus.out_valid, busy);
        end
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_addr !== AW'(i) || done !== 1'b0) begin
                fails++;
                $display("FAIL iso_recapture_idx%0d: got v=%b a=%0d d=%b, want v=1 a=%0d d=0",
                         i, bus.out_valid, bus.out_addr, done, i);
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL iso_recapture_done: got d=%b v=%b, want d=1 v=0", done, bus.out_valid);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        enable = 1'b1; bus.out_ready = 1'b1; req = 8'b1100_0001;
        @(negedge clk);
        req = '0;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 3'd0) begin
            fails++;
            $display("FAIL abort_first: got v=%b a=%0d, want v=1 a=0", bus.out_valid, bus.out_addr);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.out_addr !== 3'd0) begin
                fails++;
                $display("FAIL abort_idle%0d: got v=%b b=%b d=%b a=%0d, want all 0",
                         i, bus.out_valid, busy, done, bus.out_addr);
            end
            req = 8'h0F;
        end
        req = '0;
    endtask

    task automatic test_abort_last_bit();
        enable = 1'b1; bus.out_ready = 1'b1; req = 8'b0000_1000;
        @(negedge clk);
        req = '0;
        enable = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 3'd3) begin
            fails++;
            $display("FAIL abort_last_present: got v=%b a=%0d, want v=1 a=3", bus.out_valid, bus.out_addr);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_last_nodone: got d=%b v=%b, want d=0 v=0", done, bus.out_valid);
        end
    endtask

    task automatic test_async_reset();
        enable = 1'b1; bus.out_ready = 1'b0; req = 8'hF0;
        @(negedge clk);
        req = '0;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 3'd4 || busy !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: got v=%b a=%0d b=%b, want v=1 a=4 b=1", bus.out_valid, bus.out_addr, busy);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_addr !== 3'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL areset_immediate: got v=%b b=%b a=%0d d=%b, want all 0",
                     bus.out_valid, busy, bus.out_addr, done);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL areset_after%0d: got v=%b b=%b d=%b, want 000", i, bus.out_valid, busy, done);
            end
        end
    endtask

    task automatic test_edge_lines();
        enable = 1'b1; bus.out_ready = 1'b1; req = 8'b1000_0000;
        @(negedge clk);
        req = '0;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 3'd7) begin
            fails++;
            $display("FAIL edge_top: got v=%b a=%0d, want v=1 a=7", bus.out_valid, bus.out_addr);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL edge_top_done: got d=%b v=%b, want d=1 v=0", done, bus.out_valid);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL edge_zero_idle%0d: got v=%b d=%b b=%b, want 000", i, bus.out_valid, done, busy);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_snapshot_isolation();
        test_abort();
        test_abort_last_bit();
        test_async_reset();
        test_edge_lines();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/event_encoder.md
# event_encoder

Sequential encoder that turns a multi-hot request vector (one bit per pixel row or column) into a serial stream of binary indices, the inverse of the one-hot select decoder. The block captures a snapshot of pending requests, then emits the index of each set bit in ascending order over a valid/ready handshake. It sits between the pixel array's request lines and the readout controller, which consumes one address per accepted transfer.

## Interface
- `width`, default 8: number of request lines; must be ≥ 2. Address width is `$clog2(width)`.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset: state clears immediately while `reset` = 0.
- `enable`  input  1  permits capture; deassertion aborts an active scan.
- `req`  input  width  request lines; bit i set = line i pending.
- `out_ready`  input  1  consumer accepts `out_addr` this cycle.
- `out_valid`  output  1  `out_addr` holds a valid index.
- `out_addr`  output  $clog2(width)  index of the lowest pending request.
- `busy`  output  1  a snapshot is being emitted.
- `done`  output  1  one-cycle pulse after the last index of a snapshot is accepted.

## Operation
- Internal `pending` register, width bits; two states: IDLE and EMIT.
- IDLE: if `enable` = 1 and `req` != 0 at a rising edge, then `pending` <= `req` and state goes to EMIT. Otherwise remain in IDLE.
- EMIT: `out_valid` = 1. `out_addr` = index of the lowest set bit of `pending`, decoded combinationally from the register.
- Transfer occurs when `out_valid` and `out_ready` are both high at a rising edge. On transfer, the emitted bit is cleared in `pending`.
- If the transfer clears the last bit, the next state is IDLE, `done` = 1 for exactly one cycle, and `pending` = 0.
- `req` is ignored while in EMIT. New requests wait for the next capture.
- `enable` = 0 in EMIT aborts the scan: at the next edge go to IDLE and clear `pending`.
  - A transfer in that same cycle still counts as accepted.
  - Abort never asserts `done`, even when the aborted transfer held the last bit.
- Outputs when not valid: `out_addr` = 0 and `busy` = 0. `busy` = 1 exactly in EMIT.
- `out_addr`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from `req` or `out_ready` to any output.

## Timing
- Reset values: state IDLE, `pending` = 0, `out_valid` = 0, `out_addr` = 0, `busy` = 0, `done` = 0.
- Reset takes effect asynchronously. Release is sampled at the next rising edge.
- Latency: capture edge → `out_valid` high in the following cycle.
- Throughput: one index per cycle while `out_ready` stays high. A snapshot with N set bits occupies exactly N EMIT cycles without backpressure.
- Backpressure: while `out_ready` = 0, `out_valid` and `out_addr` stay stable.
- `done` is high in the first IDLE cycle after completion. A new capture may occur at the edge that ends that cycle, so there is a minimum one-cycle gap between snapshots.
- Reset asserted mid-scan discards the snapshot. Outputs go to their reset values without waiting for a clock edge.
- `req` = 0 with `enable` = 1 keeps the block in IDLE indefinitely, with no spurious `out_valid` or `done`.

## Test plan
- Basic scan: reset, then `enable` = 1, `out_ready` = 1, `req` = 8'b1010_0100 for one cycle → `out_addr` 2, 5, 7 on three consecutive valid cycles, then `done` pulses for one cycle and `busy` = 0.
- Backpressure: `req` = 8'b0000_0011, `out_ready` = 0 for 3 cycles → `out_addr` = 0 held stable with `out_valid` = 1. Then `out_ready` = 1 → 0 then 1, then `done`.
- Snapshot isolation: capture `req` = 8'b0001_0000, then change `req` to 8'hFF during EMIT → only index 4 emitted. The next capture, taken on the edge after `done`, emits 0 through 7.
- Abort: capture 8'b1100_0001, accept index 0, then drop `enable` → `out_valid` low next cycle, `busy` = 0, no `done`. Index 6 is never emitted.
- Async reset mid-scan: pull `reset` low between clock edges during EMIT → `out_valid`, `busy` and `out_addr` = 0 immediately. After release with `req` = 0, outputs stay idle.
- Edge lines: `req` = 8'b1000_0000 → single index 7 then `done`. `req` = 0 → no activity for 20 cycles.
